// File: rtl/sft_arbiter_scrub.sv
// Triple-redundant arbiter: three state replicas are majority-voted and rewritten every cycle.
// Defining SFT_ARBITER_FAULT_INJECT_EN adds inj_en/inj_replica/inj_mask for upsetting one replica's grant.
module sft_arbiter_scrub #(
    parameter int PORTS                 = 4,
    parameter int ARB_TYPE_ROUND_ROBIN  = 0,
    parameter int ARB_BLOCK             = 0,
    parameter int ARB_BLOCK_ACK         = 1,
    parameter int ARB_LSB_HIGH_PRIORITY = 0,
    parameter int ERR_CNT_WIDTH         = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PORTS-1:0]         request,
    input  logic [PORTS-1:0]         acknowledge,
    output logic [PORTS-1:0]         grant,
    output logic                     grant_valid,
    output logic [$clog2(PORTS)-1:0] grant_encoded,
    input  logic                     err_clear,
    output logic                     tmr_err,
    output logic [2:0]               err_replica,
    output logic [ERR_CNT_WIDTH-1:0] err_count
`ifdef SFT_ARBITER_FAULT_INJECT_EN
    ,
    input  logic                     inj_en,
    input  logic [1:0]               inj_replica,
    input  logic [PORTS-1:0]         inj_mask
`endif
);
    localparam int IDX_W = $clog2(PORTS);

    typedef struct packed {
        logic [PORTS-1:0] grant;
        logic             valid;
        logic [IDX_W-1:0] enc;
        logic [PORTS-1:0] mask;
    } arb_state_t;

    localparam arb_state_t RESET_STATE = '{grant: '0, valid: 1'b0, enc: '0, mask: '1};

    arb_state_t             rep_q [3];
    arb_state_t             rep_d [3];
    arb_state_t             voted;
    arb_state_t             next_state;
    logic                   hold;
    logic [PORTS-1:0]       cand;
    logic [IDX_W-1:0]       win_idx;
    logic [2:0]             fault;
    logic                   tmr_err_q, tmr_err_d;
    logic [2:0]             err_replica_q, err_replica_d;
    logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;

    function automatic logic [IDX_W-1:0] pick_winner(input logic [PORTS-1:0] req);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (ARB_LSB_HIGH_PRIORITY != 0) begin
                if (req[PORTS-1-i]) idx = IDX_W'(PORTS-1-i);
            end else if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    assign voted = arb_state_t'((rep_q[0] & rep_q[1]) | (rep_q[0] & rep_q[2]) | (rep_q[1] & rep_q[2]));

    assign grant         = voted.grant;
    assign grant_valid   = voted.valid;
    assign grant_encoded = voted.enc;
    assign tmr_err       = tmr_err_q;
    assign err_replica   = err_replica_q;
    assign err_count     = err_count_q;

    always_comb begin
        hold = 1'b0;
        if (ARB_BLOCK != 0) begin
            if (ARB_BLOCK_ACK != 0) hold = voted.valid && ((voted.grant & acknowledge) == '0);
            else                    hold = (voted.grant & request) != '0;
        end
        cand = request;
        if ((ARB_TYPE_ROUND_ROBIN != 0) && ((request & voted.mask) != '0)) cand = request & voted.mask;
        win_idx = pick_winner(cand);

        next_state = voted;
        if (!hold) begin
            if (request != '0) begin
                next_state.grant          = '0;
                next_state.grant[win_idx] = 1'b1;
                next_state.valid          = 1'b1;
                next_state.enc            = win_idx;
                // The mask keeps only ports that rank below the winner, so they go first next time.
                for (int j = 0; j < PORTS; j++) begin
                    if (ARB_LSB_HIGH_PRIORITY != 0) next_state.mask[j] = (j > int'(win_idx));
                    else                            next_state.mask[j] = (j < int'(win_idx));
                end
            end else begin
                next_state.grant = '0;
                next_state.valid = 1'b0;
                next_state.enc   = '0;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            rep_d[k] = next_state;
`ifdef SFT_ARBITER_FAULT_INJECT_EN
            if (inj_en && (inj_replica == 2'(k))) rep_d[k].grant = next_state.grant ^ inj_mask;
`endif
            fault[k] = (rep_q[k] != voted);
        end
    end

    always_comb begin
        tmr_err_d = |fault;
        if (err_clear) begin
            err_replica_d = fault;
            err_count_d   = (|fault) ? ERR_CNT_WIDTH'(1) : '0;
        end else begin
            err_replica_d = err_replica_q | fault;
            err_count_d   = err_count_q;
            if ((|fault) && (err_count_q != '1)) err_count_d = err_count_q + ERR_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) rep_q[k] <= RESET_STATE;
            tmr_err_q     <= 1'b0;
            err_replica_q <= '0;
            err_count_q   <= '0;
        end else begin
            for (int k = 0; k < 3; k++) rep_q[k] <= rep_d[k];
            tmr_err_q     <= tmr_err_d;
            err_replica_q <= err_replica_d;
            err_count_q   <= err_count_d;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(voted.grant) && (voted.valid == (|voted.grant)))
                else $error("voted grant is not one-hot or disagrees with valid");
        end
    end
`endif

endmodule
